// File: rtl/upbus_pkg.sv
// Shared widths, default error data and FSM encoding for the upbus transaction sequencer.
package upbus_pkg;

  localparam int unsigned AW  = 24;
  localparam int unsigned DW  = 32;
  localparam int unsigned PAW = 12;

  localparam logic [DW-1:0] ERR_DATA_DEF = 32'hBADB_AD00;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StDecode = ST_DECODE,
    StAccess = ST_ACCESS,
    StDone   = ST_DONE
  } state_e;

endpackage

// File: rtl/upbus_dec.sv
// Base-address decoder: matches addr_hi_i against every part base, lowest index wins.
module upbus_dec
  import upbus_pkg::*;
#(
  parameter int unsigned          NPART = 4,
  parameter logic [NPART*PAW-1:0] BASE  = {12'h100, 12'h0f0, 12'h000, 12'hf00},
  parameter int unsigned          IdxW  = (NPART > 1) ? $clog2(NPART) : 1
) (
  input  logic [PAW-1:0]   addr_hi_i,
  output logic             hit_o,
  output logic [NPART-1:0] hit_oh_o,
  output logic [IdxW-1:0]  hit_idx_o
);

  always_comb begin
    hit_o     = 1'b0;
    hit_idx_o = '0;
    hit_oh_o  = '0;
    // Descending scan so the lowest matching index is the last one written.
    for (int i = int'(NPART) - 1; i >= 0; i--) begin
      if (addr_hi_i == BASE[i*PAW +: PAW]) begin
        hit_o     = 1'b1;
        hit_idx_o = IdxW'(i);
      end
    end
    if (hit_o) begin
      hit_oh_o[hit_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/upbus_seq.sv
// Registered, timeout-protected sequencer from the external CPU bus onto NPART part buses.
// Optional UPBUS_ERRCNT_EN adds a saturating err_cnt output counting timeout/unmapped events.
module upbus_seq
  import upbus_pkg::*;
#(
  parameter int unsigned          NPART    = 4,
  parameter logic [NPART*PAW-1:0] BASE     = {12'h100, 12'h0f0, 12'h000, 12'hf00},
  parameter int unsigned          TMO_W    = 8,
  parameter logic [TMO_W-1:0]     TMO_MAX  = 8'd200,
  parameter logic [DW-1:0]        ERR_DATA = ERR_DATA_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       eupa,
  input  logic                eupce_,
  input  logic                euprnw,
  input  logic [DW-1:0]       eupdi,
  output logic [DW-1:0]       eupdo,
  output logic                eupack,
  output logic [NPART-1:0]    upce_,
  output logic [PAW-1:0]      upa,
  output logic [DW-1:0]       updi,
  output logic                uprnw,
  input  logic [NPART*DW-1:0] updo,
  input  logic [NPART-1:0]    upack,
  output logic                tmo_err,
  output logic                map_err,
  output logic [AW-1:0]       err_addr,
  input  logic                err_clr
`ifdef UPBUS_ERRCNT_EN
  ,
  output logic [15:0]         err_cnt
`endif
);

  localparam int unsigned IdxW = (NPART > 1) ? $clog2(NPART) : 1;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [IdxW-1:0]  sel_q, sel_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic [DW-1:0]    eupdo_q, eupdo_d, updi_q, updi_d;
  logic             eupack_q, eupack_d, uprnw_q, uprnw_d;
  logic [NPART-1:0] upce_q, upce_d;
  logic [PAW-1:0]   upa_q, upa_d;
  logic             tmo_err_q, tmo_err_d, map_err_q, map_err_d;
  logic [AW-1:0]    err_addr_q, err_addr_d;
  logic             tmo_set, map_set;

  logic             hit;
  logic [NPART-1:0] hit_oh;
  logic [IdxW-1:0]  hit_idx;

  upbus_dec #(
    .NPART (NPART),
    .BASE  (BASE),
    .IdxW  (IdxW)
  ) u_dec (
    .addr_hi_i (addr_q[AW-1:PAW]),
    .hit_o     (hit),
    .hit_oh_o  (hit_oh),
    .hit_idx_o (hit_idx)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wd_d     = wd_q;
    eupdo_d  = eupdo_q;
    eupack_d = eupack_q;
    upce_d   = upce_q;
    upa_d    = upa_q;
    updi_d   = updi_q;
    uprnw_d  = uprnw_q;
    tmo_set  = 1'b0;
    map_set  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!eupce_) begin
          addr_d  = eupa;
          upa_d   = eupa[PAW-1:0];
          updi_d  = eupdi;
          uprnw_d = euprnw;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (eupce_) begin
          state_d = StIdle;
        end else if (hit) begin
          sel_d   = hit_idx;
          upce_d  = ~hit_oh;
          wd_d    = '0;
          state_d = StAccess;
        end else begin
          map_set  = 1'b1;
          eupdo_d  = uprnw_q ? ERR_DATA : '0;
          eupack_d = 1'b1;
          state_d  = StDone;
        end
      end
      StAccess: begin
        // Abort beats ack; ack beats the terminal watchdog cycle.
        if (eupce_) begin
          upce_d  = '1;
          state_d = StIdle;
        end else if (upack[sel_q]) begin
          eupdo_d  = uprnw_q ? updo[sel_q*DW +: DW] : '0;
          upce_d   = '1;
          eupack_d = 1'b1;
          state_d  = StDone;
        end else if (wd_q == TMO_MAX) begin
          tmo_set  = 1'b1;
          eupdo_d  = uprnw_q ? ERR_DATA : '0;
          upce_d   = '1;
          eupack_d = 1'b1;
          state_d  = StDone;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 1'b1;
        end
      end
      StDone: begin
        if (eupce_) begin
          eupack_d = 1'b0;
          eupdo_d  = '0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    tmo_err_d  = err_clr ? 1'b0 : (tmo_err_q | tmo_set);
    map_err_d  = err_clr ? 1'b0 : (map_err_q | map_set);
    err_addr_d = err_clr ? '0 : ((tmo_set | map_set) ? addr_q : err_addr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      sel_q      <= '0;
      wd_q       <= '0;
      eupdo_q    <= '0;
      eupack_q   <= 1'b0;
      upce_q     <= '1;
      upa_q      <= '0;
      updi_q     <= '0;
      uprnw_q    <= 1'b1;
      tmo_err_q  <= 1'b0;
      map_err_q  <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      wd_q       <= wd_d;
      eupdo_q    <= eupdo_d;
      eupack_q   <= eupack_d;
      upce_q     <= upce_d;
      upa_q      <= upa_d;
      updi_q     <= updi_d;
      uprnw_q    <= uprnw_d;
      tmo_err_q  <= tmo_err_d;
      map_err_q  <= map_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign eupdo    = eupdo_q;
  assign eupack   = eupack_q;
  assign upce_    = upce_q;
  assign upa      = upa_q;
  assign updi     = updi_q;
  assign uprnw    = uprnw_q;
  assign tmo_err  = tmo_err_q;
  assign map_err  = map_err_q;
  assign err_addr = err_addr_q;

`ifdef UPBUS_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if ((tmo_set | map_set) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
